// File: rtl/lane_serializer.sv
// Lane serializer: captures a 96-bit word of eight 12-bit lanes and streams it out one lane per cycle.
// Optional LSB-first emission order is selected by defining LANE_SERIALIZER_LSB_FIRST_EN.
module lane_serializer #(
  parameter int LANE_W = 12,
  parameter int LANES  = 8,
  parameter int IDX_W  = 3,
  parameter int DROP_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANE_W*LANES-1:0]   in_data,
  input  logic                      in_ok,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W-1:0]         out_lane,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  output logic [DROP_W-1:0]         drop_cnt
);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(LANES - 1);

`ifdef LANE_SERIALIZER_LSB_FIRST_EN
  localparam logic [IDX_W-1:0] IDX_FIRST = '0;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_MAX;
`else
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_MAX;
  localparam logic [IDX_W-1:0] IDX_LAST  = '0;
`endif

  state_e                    state_q;
  logic [IDX_W-1:0]          cnt_q, cnt_d;
  logic [LANE_W*LANES-1:0]   held_q;
  logic [DROP_W-1:0]         drop_q, drop_d;
  logic                      send;
  logic                      in_xfer;
  logic                      out_xfer;

  // NOTE: every signal written here gets a value on every path first, so no latch can be inferred.
  always_comb begin
    send      = (state_q == S_SEND);
    out_valid = send;
    out_idx   = send ? cnt_q : '0;
    out_last  = send && (cnt_q == IDX_LAST);
    out_lane  = send ? held_q[int'(cnt_q)*LANE_W +: LANE_W] : '0;
    // The next word may enter in the same cycle the final lane leaves.
    in_ready  = !send || (out_last && out_ready);
    in_xfer   = in_valid && in_ready;
    out_xfer  = out_valid && out_ready;
    drop_d    = (drop_q == '1) ? drop_q : drop_q + 1'b1;
`ifdef LANE_SERIALIZER_LSB_FIRST_EN
    cnt_d     = cnt_q + 1'b1;
`else
    cnt_d     = cnt_q - 1'b1;
`endif
  end

  assign drop_cnt = drop_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the held word is a plain register (not a memory), so it is cleared with the rest.
      state_q <= S_IDLE;
      cnt_q   <= '0;
      held_q  <= '0;
      drop_q  <= '0;
    end else if (in_xfer) begin
      // In SEND an input transfer implies the last lane is leaving this cycle.
      if (in_ok) begin
        held_q  <= in_data;
        cnt_q   <= IDX_FIRST;
        state_q <= S_SEND;
      end else begin
        drop_q  <= drop_d;
        state_q <= S_IDLE;
      end
    end else if (out_xfer) begin
      if (out_last) begin
        state_q <= S_IDLE;
      end else begin
        cnt_q   <= cnt_d;
      end
    end
  end

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: directed scenarios plus random traffic against a queue model.
// Honours LANE_SERIALIZER_LSB_FIRST_EN to select the expected lane order.
module tb_lane_serializer;

  typedef struct {
    logic [11:0] lane;
    logic [2:0]  idx;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic        in_ok;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_lane;
  logic [2:0]  out_idx;
  logic        out_last;
  logic [7:0]  drop_cnt;

  int    n_checks = 0;
  int    n_errors = 0;
  int    raw_drops = 0;
  int    n_out_xfers = 0;
  beat_t exp_q[$];

  localparam logic [95:0] W1 = 96'h0BB_0AA_099_088_077_066_055_044;
  localparam logic [95:0] W2 = {8{12'h00F}};

  lane_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ok     (in_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_drops();
    return (raw_drops > 255) ? 8'd255 : 8'(raw_drops);
  endfunction

  // Lane order derived directly from the word: MSB-first by default, LSB-first when enabled.
  task automatic push_word(input logic [95:0] w);
    beat_t b;
    for (int k = 0; k < 8; k++) begin
`ifdef LANE_SERIALIZER_LSB_FIRST_EN
      b.idx = 3'(k);
`else
      b.idx = 3'(7 - k);
`endif
      b.lane = w[int'(b.idx)*12 +: 12];
      b.last = (k == 7);
      exp_q.push_back(b);
    end
  endtask

  // Called just after a rising edge: drive, check outputs, advance one clock, update the model.
  task automatic cycle(input logic iv, input logic ok, input logic [95:0] d, input logic ordy);
    logic exp_ov, exp_ir;
    in_valid  = iv;
    in_ok     = ok;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ov = (exp_q.size() != 0);
    exp_ir = !exp_ov || (exp_q[0].last && ordy);
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(exp_ir));
    check("drop_cnt", 32'(drop_cnt), 32'(exp_drops()));
    if (exp_ov) begin
      check("out_lane", 32'(out_lane), 32'(exp_q[0].lane));
      check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
      check("out_last", 32'(out_last), 32'(exp_q[0].last));
    end
    @(posedge clk);
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      n_out_xfers++;
    end
    if (iv && exp_ir) begin
      if (ok) push_word(d);
      else raw_drops++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ok    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    raw_drops = 0;
  endtask

  initial begin
    logic [11:0] first_w1, first_w2, last_w1;
    logic [2:0]  first_idx, last_idx;
    logic        bp [11];
`ifdef LANE_SERIALIZER_LSB_FIRST_EN
    first_w1 = 12'h044; last_w1 = 12'h0BB; first_idx = 3'd0; last_idx = 3'd7;
`else
    first_w1 = 12'h0BB; last_w1 = 12'h044; first_idx = 3'd7; last_idx = 3'd0;
`endif
    first_w2 = 12'h00F;
    bp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_ok = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_lane", 32'(out_lane), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    @(posedge clk);
    #1;

    // Single word, free-flowing output.
    cycle(1'b1, 1'b1, W1, 1'b1);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    check("single_first_lane", 32'(out_lane), 32'(first_w1));
    check("single_first_idx", 32'(out_idx), 32'(first_idx));
    #1;
    @(posedge clk);
    #1;
    exp_q.delete();
    push_word(W1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    out_ready = 1'b1;
    #1;
    check("single_last_lane", 32'(out_lane), 32'(last_w1));
    check("single_last_idx", 32'(out_idx), 32'(last_idx));
    check("single_last_flag", 32'(out_last), 32'd1);
    #1;
    cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Backpressure for three cycles at the third lane.
    n_out_xfers = 0;
    cycle(1'b1, 1'b1, W1, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b0, 1'b0, '0, bp[i]);
    check("bp_xfer_count", 32'(n_out_xfers), 32'd8);
    cycle(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back words with no bubble.
    cycle(1'b1, 1'b1, W1, 1'b1);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    cycle(1'b1, 1'b1, W2, 1'b1);
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_lane", 32'(out_lane), 32'(first_w2));
    check("b2b_idx", 32'(out_idx), 32'(first_idx));
    #1;
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Invalid words are dropped and counted, saturating at 255.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 96'(i), 1'b1);
    #1;
    check("drop3", 32'(drop_cnt), 32'd3);
    #1;
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, '1, 1'(i));
    #1;
    check("drop_sat", 32'(drop_cnt), 32'd255);
    #1;

    // Reset after the third lane transfers aborts the word.
    cycle(1'b1, 1'b1, W1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    out_ready = 1'b1;
    do_reset();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    #1;
    cycle(1'b1, 1'b1, W2, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, '0, 1'b1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [95:0] rd;
      rd = {$urandom(), $urandom(), $urandom()};
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), rd,
            ($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1);
    check("drain_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lane_serializer.md
Name: lane_serializer

Overview:
- Downstream consumer of the 96-bit lane-shift stage.
- Captures one 96-bit word, made of eight 12-bit lanes, together with the shifter's validity flag.
- Emits the word one lane per cycle on a 12-bit valid/ready stream.
- Drops words the shifter flagged invalid (shift codes 6 and 7) and counts them.

Parameters:
- LANE_W, 12, width of one lane in bits.
- LANES, 8, number of lanes per input word. Input width is LANE_W*LANES.
- IDX_W, 3, width of the lane index. Must satisfy 2**IDX_W >= LANES.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  96  word from the shifter's out bus.
- in_ok  input  1  shifter's out_valid; 0 means the word is invalid.
- out_valid  output  1  lane present on out_lane.
- out_ready  input  1  downstream accepts the lane.
- out_lane  output  12  current lane value.
- out_idx  output  3  index of the current lane within the word.
- out_last  output  1  current lane is the final lane of the word.
- drop_cnt  output  8  number of invalid words dropped; saturates at 255.

Behaviour:
- Reset: every output is 0 except in_ready, which is 1. State goes to IDLE, the lane counter to 0, the held word to 0, and drop_cnt to 0.
- A reset asserted mid-word aborts the word; no further lanes of it are emitted.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Output stability: while out_valid=1 and out_ready=0, out_lane, out_idx and out_last hold stable. out_valid never drops without a transfer.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an input transfer with in_ok=1: register in_data, set the counter to 7, go to SEND.
  - On an input transfer with in_ok=0: discard the word, drop_cnt += 1 (saturating), stay in IDLE.
- State SEND:
  - out_valid=1.
  - out_lane = held[counter*12 +: 12], out_idx = counter, out_last = (counter==0).
  - Order is MSB-first: the first lane emitted is bits 95:84 with idx 7.
  - On an output transfer with counter>0: counter -= 1.
  - On an output transfer with out_last=1: the word is complete.
- in_ready in SEND:
  - in_ready = out_last && out_ready (combinational). This gives zero-bubble back-to-back words.
  - If the last lane transfers and an input transfer with in_ok=1 happens in the same cycle: load the new word, set counter to 7, stay in SEND.
  - Same cycle but in_ok=0: count the drop and go to IDLE.
  - Last lane transfers with no input transfer: go to IDLE.
- Latency: first lane is visible the cycle after the input transfer. A word takes exactly 8 output transfers.
- Drop counter: at 255 it stays at 255; no wrap.
- in_data is sampled only on an input transfer. in_data changes at other times have no effect.

Optional Feature:
- Macro: LANE_SERIALIZER_LSB_FIRST_EN.
- When defined:
  - Lanes are emitted LSB-first; the counter starts at 0 and increments.
  - The first lane is bits 11:0 with idx 0. out_last = (counter==7).
  - in_ready in SEND follows the redefined out_last.
- When undefined: MSB-first behaviour as above.

Test Plan:
- Single word: after reset, send in_data=0x0BB_0AA_099_088_077_066_055_044 with in_ok=1 and out_ready=1.
  - Required: lanes 0x0BB,0x0AA,0x099,0x088,0x077,0x066,0x055,0x044 on consecutive cycles, idx 7..0.
  - out_last only on 0x044; in_ready returns to 1 the following cycle.
- Backpressure: same word, out_ready=0 for 3 cycles starting at the lane with idx 5.
  - Required: out_lane=0x099 and idx=5 held for all 3 cycles, then the sequence resumes.
  - Total of 8 transfers, with no duplicated or skipped lanes.
- Back-to-back: second word 0x00F repeated in all lanes, presented with in_valid=1 during the last lane of word 1.
  - Required: in_ready=1 in that cycle, and lane 0x00F with idx 7 on the very next cycle (no bubble).
- Invalid drop: three words with in_ok=0.
  - Required: out_valid stays 0 and drop_cnt=3. Then 300 invalid words → drop_cnt=255.
- Reset mid-word: assert rst after the 3rd lane transfers.
  - Required: next cycle out_valid=0, in_ready=1, drop_cnt=0. A new word starts at idx 7.
- With LANE_SERIALIZER_LSB_FIRST_EN defined, repeat the single-word test.
  - Required: 0x044 first with idx 0, 0x0BB last with out_last=1 and idx 7.
